// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller: accepts one request at a time, drives one dmem access cycle,
// and returns a registered, extended load result or error flags to writeback.
module lsu_dmem_ctrl #(
    parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
    parameter logic [63:0] MEM_BYTES = 64'h0000_0000_0800_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dmem_en,
    output logic [63:0] dmem_addr,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] dmem_wdata,
    output logic [63:0] dmem_wmask,
    output logic        dmem_wen,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_is_store,
    output logic        resp_misaligned,
    output logic        resp_fault
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        isStore_q, isStore_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] respData_q, respData_d;
    logic        misaligned_q, misaligned_d;
    logic        fault_q, fault_d;

    logic        accept;
    logic        reqMisaligned;
    logic        reqFault;
    logic [5:0]  shamt;
    logic [63:0] laneMask;
    logic [63:0] shiftedRdata;
    logic [63:0] loadExt;

    assign shamt        = {addr_q[2:0], 3'b000};
    assign shiftedRdata = dmem_rdata >> shamt;

    always_comb begin
        reqMisaligned = ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                     || ((req_size == 2'd3) && (req_addr[2:0] != 3'b000));
        // Subtraction only happens once addr >= MEM_BASE, so it cannot wrap.
        reqFault = (req_addr < MEM_BASE) || ((req_addr - MEM_BASE) >= MEM_BYTES);
    end

    always_comb begin
        laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
        loadExt  = shiftedRdata;
        case (size_q)
            2'd0: begin
                laneMask = 64'h0000_0000_0000_00FF;
                loadExt  = unsigned_q ? {56'd0, shiftedRdata[7:0]}
                                      : {{56{shiftedRdata[7]}}, shiftedRdata[7:0]};
            end
            2'd1: begin
                laneMask = 64'h0000_0000_0000_FFFF;
                loadExt  = unsigned_q ? {48'd0, shiftedRdata[15:0]}
                                      : {{48{shiftedRdata[15]}}, shiftedRdata[15:0]};
            end
            2'd2: begin
                laneMask = 64'h0000_0000_FFFF_FFFF;
                loadExt  = unsigned_q ? {32'd0, shiftedRdata[31:0]}
                                      : {{32{shiftedRdata[31]}}, shiftedRdata[31:0]};
            end
            default: begin
                laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
                loadExt  = shiftedRdata;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        isStore_d    = isStore_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        respData_d   = respData_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;
        dmem_en      = 1'b0;
        dmem_wen     = 1'b0;
        dmem_addr    = 64'd0;
        dmem_wdata   = 64'd0;
        dmem_wmask   = 64'd0;
        req_ready    = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
        accept       = req_valid && req_ready;

        case (state_q)
            ACCESS: begin
                dmem_en    = 1'b1;
                dmem_wen   = isStore_q;
                dmem_addr  = {addr_q[63:3], 3'b000};
                dmem_wdata = wdata_q << shamt;
                dmem_wmask = laneMask << shamt;
                if (!isStore_q) begin
                    respData_d = loadExt;
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A new request may overlap the handoff of the previous response.
        if (accept) begin
            isStore_d    = req_is_store;
            size_d       = req_size;
            unsigned_d   = req_unsigned;
            addr_d       = req_addr;
            wdata_d      = req_wdata;
            rd_d         = req_rd;
            respData_d   = 64'd0;
            misaligned_d = reqMisaligned;
            fault_d      = reqFault;
            state_d      = (reqMisaligned || reqFault) ? RESP : ACCESS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            isStore_q    <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            rd_q         <= 5'd0;
            respData_q   <= 64'd0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            isStore_q    <= isStore_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            respData_q   <= respData_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    assign resp_valid      = (state_q == RESP);
    assign resp_data       = respData_q;
    assign resp_rd         = rd_q;
    assign resp_is_store   = isStore_q;
    assign resp_misaligned = misaligned_q;
    assign resp_fault      = fault_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a byte-addressed reference memory.
module tb_lsu_dmem_ctrl;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] BYTES = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;
    logic        dmem_wen;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_is_store;
    logic        resp_misaligned;
    logic        resp_fault;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        isStore;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] preload;
        logic [63:0] expData;
        logic        expMis;
        logic        expFault;
        logic [63:0] expMask;
        logic [63:0] expWdata;
    } vec_t;

    vec_t vecs[14];

    // Small RAM window aliased on address bits [8:3]; the reference model aliases on [8:0].
    logic [63:0] ram [64];
    logic [7:0]  refMem [512];
    logic        preloadEn = 1'b0;
    logic [5:0]  preloadIdx = 6'd0;
    logic [63:0] preloadVal = 64'd0;

    lsu_dmem_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_is_store(resp_is_store),
        .resp_misaligned(resp_misaligned), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    assign dmem_rdata = ram[dmem_addr[8:3]];

    always @(posedge clk) begin
        if (dmem_wen)
            ram[dmem_addr[8:3]] <= (ram[dmem_addr[8:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
        else if (preloadEn)
            ram[preloadIdx] <= preloadVal;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preloadWord(input logic [5:0] idx, input logic [63:0] val);
        preloadEn  = 1'b1;
        preloadIdx = idx;
        preloadVal = val;
        @(posedge clk); #1;
        preloadEn = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge, with resp_ready low.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                                 input logic [63:0] ad, input logic [63:0] wd, input logic [4:0] rd,
                                 input logic [63:0] expData, input logic [63:0] expMask,
                                 input logic [63:0] expWdata, input logic expMis,
                                 input logic expFault, input int hold);
        int waitCycles;
        logic legal;
        legal = !expMis && !expFault;
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = ad;
        req_wdata    = wd;
        req_rd       = rd;
        waitCycles   = 0;
        while (!req_ready && waitCycles < 10) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("reqReady", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ~ad;
        req_wdata = ~wd;
        if (legal) begin
            checkOutput("accessEn", 64'(dmem_en), 64'd1);
            checkOutput("accessWen", 64'(dmem_wen), 64'(st));
            checkOutput("accessAddr", dmem_addr, {ad[63:3], 3'b000});
            checkOutput("accessMask", dmem_wmask, expMask);
            checkOutput("accessWdata", dmem_wdata, expWdata);
            checkOutput("accessNoResp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end else begin
            checkOutput("errNoDmem", 64'({dmem_en, dmem_wen}), 64'd0);
        end
        checkOutput("respValid", 64'(resp_valid), 64'd1);
        checkOutput("respData", resp_data, expData);
        checkOutput("respFlags", 64'({resp_misaligned, resp_fault}), 64'({expMis, expFault}));
        checkOutput("respRd", 64'(resp_rd), 64'(rd));
        checkOutput("respIsStore", 64'(resp_is_store), 64'(st));
        checkOutput("respIdleDmem", dmem_addr | dmem_wmask | dmem_wdata | 64'(dmem_en), 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("holdValid", 64'(resp_valid), 64'd1);
            checkOutput("holdData", resp_data, expData);
            checkOutput("holdReqReady", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("backToIdle", 64'(resp_valid), 64'd0);
    endtask

    task automatic modelExpect(input logic st, input logic [1:0] sz, input logic un,
                               input logic [63:0] ad, input logic [63:0] wd,
                               output logic [63:0] expData, output logic [63:0] expMask,
                               output logic [63:0] expWdata, output logic expMis,
                               output logic expFault);
        int nb;
        int off;
        nb       = 1 << sz;
        off      = int'(ad[2:0]);
        expMis   = (ad % 64'(nb)) != 64'd0;
        expFault = (ad < BASE) || (ad >= BASE + BYTES);
        expWdata = wd << (8 * off);
        expMask  = 64'd0;
        expData  = 64'd0;
        for (int i = 0; i < nb; i++) begin
            if (off + i < 8) expMask[8*(off+i) +: 8] = 8'hFF;
        end
        if (!st && !expMis && !expFault) begin
            for (int i = 0; i < nb; i++) expData[8*i +: 8] = refMem[ad[8:0] + 9'(i)];
            if (nb < 8 && !un && expData[8*nb-1])
                expData = expData | ~((64'd1 << (8 * nb)) - 64'd1);
        end
    endtask

    task automatic backToBack();
        preloadWord(6'd8, 64'h1122_3344_5566_7788);
        preloadWord(6'd9, 64'h99AA_BBCC_DDEE_FF00);
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = BASE + 64'h40; req_wdata = 64'd0; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2bRespA", resp_data, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("b2bHoldValid", 64'(resp_valid), 64'd1);
            checkOutput("b2bHoldData", resp_data, 64'h1122_3344_5566_7788);
            checkOutput("b2bHoldRd", 64'(resp_rd), 64'd3);
            checkOutput("b2bHoldReady", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b1; req_size = 2'd2; req_unsigned = 1'b1;
        req_addr = BASE + 64'h4C; req_rd = 5'd7;
        resp_ready = 1'b1;
        #1;
        checkOutput("b2bReadyWithResp", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        checkOutput("b2bAccessEn", 64'(dmem_en), 64'd1);
        checkOutput("b2bAccessAddr", dmem_addr, BASE + 64'h48);
        checkOutput("b2bNoResp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("b2bRespBValid", 64'(resp_valid), 64'd1);
        checkOutput("b2bRespB", resp_data, 64'h0000_0000_99AA_BBCC);
        checkOutput("b2bRespBRd", 64'(resp_rd), 64'd7);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic resetMidAccess();
        preloadWord(6'd4, 64'hCAFE_F00D_DEAD_BEEF);
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = BASE + 64'h20; req_wdata = 64'h1234_5678_9ABC_DEF0; req_rd = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rstAccessWen", 64'(dmem_wen), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstWenDrop", 64'({dmem_en, dmem_wen}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rstRamKept", ram[4], 64'hCAFE_F00D_DEAD_BEEF);
        checkOutput("rstReqReady", 64'(req_ready), 64'd1);
        checkOutput("rstNoResp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [63:0] ad;
        logic [63:0] wd;
        logic [63:0] expData, expMask, expWdata;
        logic        expMis, expFault;
        int          r;

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
        resp_ready = 1'b0;

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 64'h8000_0013, 64'h12AB, 64'd0, 64'd0, 1'b0, 1'b0,
                     64'h0000_0000_FF00_0000, 64'h0000_0012_AB00_0000};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 64'h8000_0013, 64'd0, 64'h0000_0000_AB00_0000,
                     64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1'b0, 64'h0000_0000_FF00_0000, 64'd0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 64'h8000_0013, 64'd0, 64'h0000_0000_AB00_0000,
                     64'h0000_0000_0000_00AB, 1'b0, 1'b0, 64'h0000_0000_FF00_0000, 64'd0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 64'd0};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'h0000_1000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0};
        vecs[5]  = '{1'b0, 2'd3, 1'b0, 64'h8800_0000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h0000_0001, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000,
                     64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 64'hFFFF_0000_0000_0000, 64'd0};
        vecs[8]  = '{1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000,
                     64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000,
                     64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 64'h87FF_FFF8, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0,
                     1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'hFFFF_BEEF, 64'd0, 64'd0, 1'b0, 1'b0,
                     64'h0000_0000_FFFF_0000, 64'h0000_FFFF_BEEF_0000};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 64'h7FFF_FFFF, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0};
        vecs[13] = '{1'b0, 2'd3, 1'b1, 64'h8000_0008, 64'd0, 64'hF000_0000_0000_0001,
                     64'hF000_0000_0000_0001, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetReqReady", 64'(req_ready), 64'd1);
        checkOutput("resetRespValid", 64'(resp_valid), 64'd0);
        checkOutput("resetRespData", resp_data, 64'd0);
        checkOutput("resetRespMisc", 64'({resp_rd, resp_is_store, resp_misaligned, resp_fault}), 64'd0);
        checkOutput("resetDmem", dmem_addr | dmem_wdata | dmem_wmask | 64'({dmem_en, dmem_wen}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            if (!vecs[i].isStore) preloadWord(vecs[i].addr[8:3], vecs[i].preload);
            applyStimulus(vecs[i].isStore, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                          5'(i + 1), vecs[i].expData, vecs[i].expMask, vecs[i].expWdata,
                          vecs[i].expMis, vecs[i].expFault, i % 4);
        end

        backToBack();
        resetMidAccess();

        for (int w = 0; w < 64; w++) begin
            wd = {$urandom, $urandom};
            preloadWord(6'(w), wd);
            for (int b = 0; b < 8; b++) refMem[w*8 + b] = wd[8*b +: 8];
        end

        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            r  = int'($urandom_range(0, 9));
            if (r < 7)       ad = BASE + 64'($urandom_range(0, 511));
            else if (r == 7) ad = {$urandom, $urandom};
            else if (r == 8) ad = BASE - 64'($urandom_range(1, 16));
            else             ad = BASE + BYTES - 64'd16 + 64'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) ad = ad & ~((64'd1 << sz) - 64'd1);
            modelExpect(st, sz, un, ad, wd, expData, expMask, expWdata, expMis, expFault);
            applyStimulus(st, sz, un, ad, wd, 5'($urandom_range(0, 31)), expData, expMask,
                          expWdata, expMis, expFault, int'($urandom_range(0, 2)));
            if (st && !expMis && !expFault) begin
                for (int i = 0; i < (1 << sz); i++) refMem[ad[8:0] + 9'(i)] = wd[8*i +: 8];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store access controller sitting directly upstream of the data port of the shared 2-read/1-write simulation RAM. It accepts one memory request at a time from the execute stage over a valid/ready handshake and drives a single dmem access cycle. Stores get byte-lane alignment and mask generation; loads get lane extraction and sign or zero extension. It detects misaligned and out-of-range accesses without touching memory, and returns a registered response to writeback over a second valid/ready handshake.

## Interface
- MEM_BASE, 64'h0000_0000_8000_0000: first legal byte address.
- MEM_BYTES, 64'h0000_0000_0800_0000: size of the legal window in bytes.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend loads (ignored for stores and for double).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- req_rd  in  5  destination register tag, passed through.
- dmem_en  out  1  RAM access enable.
- dmem_addr  out  64  8-byte-aligned byte address.
- dmem_rdata  in  64  combinational RAM read data.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wmask  out  64  bit-level write mask.
- dmem_wen  out  1  write enable.
- resp_valid  out  1  response present.
- resp_ready  in  1  writeback accepts response.
- resp_data  out  64  extended load result; 0 for stores and errors.
- resp_rd  out  5  captured req_rd.
- resp_is_store  out  1  captured req_is_store.
- resp_misaligned  out  1  alignment error.
- resp_fault  out  1  address outside [MEM_BASE, MEM_BASE+MEM_BYTES).

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE and clears all captured registers to 0.
- req_ready = (IDLE) || (RESP && resp_ready).
- Accept: capture the request fields and compute off = addr[2:0].
  - misaligned = (half && addr[0]) || (word && addr[1:0]!=0) || (double && addr[2:0]!=0).
  - fault = addr < MEM_BASE || addr - MEM_BASE >= MEM_BYTES. Compare as 64-bit unsigned, with no wrap.
- If the accepted request is misaligned or faulting, go straight to RESP with the matching flag set. Both flags may be set together. resp_data is 0 and dmem_en is never asserted.
- Otherwise go to ACCESS.
- ACCESS, exactly one cycle:
  - dmem_en = 1; dmem_addr = {addr[63:3], 3'b000}.
  - dmem_wen = is_store.
  - dmem_wdata = wdata << (8*off).
  - dmem_wmask = lanemask << (8*off), where lanemask is 0xFF, 0xFFFF, 0xFFFF_FFFF or all-ones for byte, half, word and double.
  - Loads: on the edge, register resp_data = extend(dmem_rdata >> (8*off), size, unsigned). Sign-extend from bit 7, 15 or 31 unless req_unsigned is set.
  - Stores: the RAM commits on the same edge, and resp_data is 0.
  - The FSM then goes to RESP.
- RESP: resp_valid = 1 and all resp_* are held stable until resp_ready.
  - On resp_ready with req_valid: accept the new request on that same edge.
  - On resp_ready without req_valid: go to IDLE.
- Outside ACCESS: dmem_en = dmem_wen = 0, and dmem_addr, dmem_wdata, dmem_wmask = 0.

## Timing
- Reset values: req_ready = 1, and every other output is 0.
- Legal access: accepted at edge N, ACCESS during cycle N+1, resp_valid from cycle N+2.
- Error: accepted at edge N, resp_valid from cycle N+1.
- Sustained throughput is one legal access per 2 cycles with resp_ready held high.
- dmem_* are combinational from FSM state and captured registers only, never from req_* directly.
- Reset asserted during ACCESS: dmem_en and dmem_wen drop immediately, so no write commits on the next edge. Any pending response is discarded.
- resp_ready low never stalls an ACCESS already in progress; the response waits in RESP.

## Test plan
- Store byte: store, size 0, addr 0x8000_0013, wdata 0x12AB -> one ACCESS cycle with:
  - dmem_addr 0x8000_0010, dmem_wen 1;
  - dmem_wmask 0x0000_0000_FF00_0000, dmem_wdata 0x0000_0012_AB00_0000;
  - resp_valid 2 cycles after accept, resp_data 0.
- Signed vs unsigned byte load: addr 0x8000_0013, dmem_rdata 0x0000_0000_AB00_0000 -> signed gives 0xFFFF_FFFF_FFFF_FFAB; unsigned gives 0x0000_0000_0000_00AB.
- Misaligned: word load at 0x8000_0002 -> resp_misaligned 1 one cycle after accept, dmem_en never 1.
- Fault: double load at 0x0000_1000 and at 0x8800_0000 -> resp_fault 1, no dmem access.
- Backpressure and back-to-back:
  - Hold resp_ready low for 3 cycles -> resp_* stable and req_ready 0 throughout.
  - Raise resp_ready with req_valid high -> next request accepted on the same edge, and its ACCESS follows in the next cycle.
- Reset mid-ACCESS: assert reset during a store's ACCESS cycle -> dmem_wen falls within that cycle and RAM contents are unchanged. After reset: req_ready 1 and resp_valid 0.
